// File: rtl/student_fir_sched_pkg.sv
// -----------------------------------------------------------------------------
// student_fir_sched_pkg
// Shared types and helpers for the student FIR lane sequencer.
//   sched_state_t : sequencer FSM states
//   OVF_W/OVF_MAX : width and saturation value of the dropped-sample counter
//   lane_lsb()    : bit offset of lane k inside a packed per-lane vector
// -----------------------------------------------------------------------------
package student_fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } sched_state_t;

  localparam int unsigned OVF_W = 16;
  localparam logic [OVF_W-1:0] OVF_MAX = 16'hFFFF;

  // Lane k occupies [k*width +: width] in every packed per-lane vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/student_fir_sched_fifo.sv
// -----------------------------------------------------------------------------
// student_fir_sched_fifo
// Synchronous show-ahead FIFO with registered full/empty flags.
// A push while full is dropped regardless of a same-cycle pop, so the flags
// only ever depend on registered state.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   push_i, data_i write request and data (ignored while full)
//   pop_i          read request (ignored while empty)
//   data_o         current head entry
//   full_o/empty_o registered occupancy flags
// -----------------------------------------------------------------------------
module student_fir_sched_fifo
  import student_fir_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_next_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push_i && !full_r;
  assign pop_ok_s  = pop_i && !empty_r;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_next_s = cnt_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_next_s = cnt_r + CNT_ONE;
      2'b01:   cnt_next_s = cnt_r - CNT_ONE;
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      cnt_r   <= cnt_next_s;
      full_r  <= (cnt_next_s == CNT_FULL);
      empty_r <= (cnt_next_s == {CW{1'b0}});
    end
  end

  // Storage array; contents need no reset because empty_r guards reads.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  assign data_o  = mem_r[rd_ptr_r];
  assign full_o  = full_r;
  assign empty_o = empty_r;

endmodule

// File: rtl/student_fir_sched.sv
// -----------------------------------------------------------------------------
// student_fir_sched
// Sequencer in front of NUM_LANES student FIR cores sharing one sample stream.
// Samples are buffered in a FIFO, broadcast to all lanes with a one-cycle
// strobe, and the per-lane results are collected until every lane is done or
// the watchdog expires; then one aligned result vector is emitted.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   enable_i              permit issuing new samples
//   clear_err_i           clear err_timeout_o and ovf_cnt_o
//   smp_valid_i, smp_i    upstream sample, smp_ready_o = FIFO not full
//   fir_strobe_o/sample_o broadcast to the lanes
//   fir_done_i, fir_y_i   per-lane completion pulses and results
//   out_valid_o, out_y_o  aligned result pulse and vector
//   out_miss_o            lanes that timed out
//   busy_o, err_timeout_o, ovf_cnt_o  status
// -----------------------------------------------------------------------------
module student_fir_sched
  import student_fir_sched_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned DATA_SIZE_OUT  = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic                               clear_err_i,
  input  logic                               smp_valid_i,
  input  logic [DATA_SIZE-1:0]               smp_i,
  output logic                               smp_ready_o,
  output logic                               fir_strobe_o,
  output logic [DATA_SIZE-1:0]               fir_sample_o,
  input  logic [NUM_LANES-1:0]               fir_done_i,
  input  logic [NUM_LANES*DATA_SIZE_OUT-1:0] fir_y_i,
  output logic                               out_valid_o,
  output logic [NUM_LANES*DATA_SIZE_OUT-1:0] out_y_o,
  output logic [NUM_LANES-1:0]               out_miss_o,
  output logic                               busy_o,
  output logic                               err_timeout_o,
  output logic [15:0]                        ovf_cnt_o
);

  localparam int unsigned LANE_W = NUM_LANES * DATA_SIZE_OUT;
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1'b1);

  sched_state_t             state_r;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [DATA_SIZE-1:0]     fifo_head_s;
  logic                     start_s;
  logic                     ovf_evt_s;
  logic                     timeout_evt_s;
  logic                     all_done_s;
  logic                     wd_exp_s;
  logic [NUM_LANES-1:0]     new_done_s;
  logic [NUM_LANES-1:0]     done_all_s;
  logic [NUM_LANES-1:0]     done_r;
  logic [LANE_W-1:0]        cap_r;
  logic [LANE_W-1:0]        cap_next_s;
  logic [LANE_W-1:0]        res_s;
  logic [WD_W-1:0]          wd_cnt_r;
  logic                     fir_strobe_r;
  logic [DATA_SIZE-1:0]     fir_sample_r;
  logic                     out_valid_r;
  logic [LANE_W-1:0]        out_y_r;
  logic [NUM_LANES-1:0]     out_miss_r;
  logic                     busy_r;
  logic                     err_r;
  logic [OVF_W-1:0]         ovf_r;

  // The FIFO head is popped in the same cycle the FSM commits to ISSUE.
  assign start_s   = (state_r == IDLE) && !fifo_empty_s && enable_i;
  assign ovf_evt_s = smp_valid_i && fifo_full_s;

  student_fir_sched_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (smp_valid_i),
    .pop_i   (start_s),
    .data_i  (smp_i),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Done/capture bookkeeping: only first pulses in ISSUE or WAIT count.
  always_comb begin
    new_done_s = {NUM_LANES{1'b0}};
    if ((state_r == ISSUE) || (state_r == WAIT)) begin
      new_done_s = fir_done_i & ~done_r;
    end else begin
      new_done_s = {NUM_LANES{1'b0}};
    end
    done_all_s = done_r | new_done_s;
    cap_next_s = cap_r;
    res_s      = {LANE_W{1'b0}};
    for (int k = 0; k < NUM_LANES; k++) begin
      if (new_done_s[k]) begin
        cap_next_s[lane_lsb(k, DATA_SIZE_OUT) +: DATA_SIZE_OUT] =
          fir_y_i[lane_lsb(k, DATA_SIZE_OUT) +: DATA_SIZE_OUT];
      end else begin
        cap_next_s[lane_lsb(k, DATA_SIZE_OUT) +: DATA_SIZE_OUT] =
          cap_r[lane_lsb(k, DATA_SIZE_OUT) +: DATA_SIZE_OUT];
      end
      // Missing lanes report zero rather than a stale capture.
      if (done_all_s[k]) begin
        res_s[lane_lsb(k, DATA_SIZE_OUT) +: DATA_SIZE_OUT] =
          cap_next_s[lane_lsb(k, DATA_SIZE_OUT) +: DATA_SIZE_OUT];
      end else begin
        res_s[lane_lsb(k, DATA_SIZE_OUT) +: DATA_SIZE_OUT] = {DATA_SIZE_OUT{1'b0}};
      end
    end
  end

  assign all_done_s    = &done_all_s;
  assign wd_exp_s      = (wd_cnt_r == WD_LAST);
  assign timeout_evt_s = (state_r == WAIT) && wd_exp_s && !all_done_s;

  // Sequencer FSM with registered lane and result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      fir_strobe_r <= 1'b0;
      fir_sample_r <= {DATA_SIZE{1'b0}};
      out_valid_r  <= 1'b0;
      out_y_r      <= {LANE_W{1'b0}};
      out_miss_r   <= {NUM_LANES{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= {NUM_LANES{1'b0}};
      cap_r        <= {LANE_W{1'b0}};
      wd_cnt_r     <= {WD_W{1'b0}};
    end else begin
      fir_strobe_r <= 1'b0;
      out_valid_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r      <= ISSUE;
            fir_strobe_r <= 1'b1;
            fir_sample_r <= fifo_head_s;
            busy_r       <= 1'b1;
            done_r       <= {NUM_LANES{1'b0}};
            cap_r        <= {LANE_W{1'b0}};
            wd_cnt_r     <= {WD_W{1'b0}};
          end else begin
            busy_r <= 1'b0;
          end
        end
        ISSUE: begin
          state_r <= WAIT;
          busy_r  <= 1'b1;
          done_r  <= done_all_s;
          cap_r   <= cap_next_s;
        end
        WAIT: begin
          busy_r <= 1'b1;
          done_r <= done_all_s;
          cap_r  <= cap_next_s;
          // Saturate so a stuck state can never wrap back below the limit.
          if (wd_cnt_r != WD_MAX) begin
            wd_cnt_r <= wd_cnt_r + WD_ONE;
          end
          if (all_done_s || wd_exp_s) begin
            state_r     <= OUT;
            out_valid_r <= 1'b1;
            out_y_r     <= res_s;
            out_miss_r  <= ~done_all_s;
          end
        end
        OUT: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky timeout flag and saturating drop counter; set/increment beats clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
      ovf_r <= {OVF_W{1'b0}};
    end else begin
      if (timeout_evt_s) begin
        err_r <= 1'b1;
      end else if (clear_err_i) begin
        err_r <= 1'b0;
      end
      if (ovf_evt_s) begin
        if (ovf_r != OVF_MAX) begin
          ovf_r <= ovf_r + 16'h0001;
        end
      end else if (clear_err_i) begin
        ovf_r <= {OVF_W{1'b0}};
      end
    end
  end

  assign smp_ready_o   = ~fifo_full_s;
  assign fir_strobe_o  = fir_strobe_r;
  assign fir_sample_o  = fir_sample_r;
  assign out_valid_o   = out_valid_r;
  assign out_y_o       = out_y_r;
  assign out_miss_o    = out_miss_r;
  assign busy_o        = busy_r;
  assign err_timeout_o = err_r;
  assign ovf_cnt_o     = ovf_r;

endmodule

// File: tb/tb_student_fir_sched.sv
// -----------------------------------------------------------------------------
// tb_student_fir_sched
// Self-checking bench: a lane responder emulates the FIR cores (per-lane done
// delays, random results), a monitor logs strobes and results, and a
// behavioural model derives the expected result vector and its timing.
// -----------------------------------------------------------------------------
module tb_student_fir_sched;

  localparam int NL  = 4;
  localparam int DW  = 16;
  localparam int DWO = 32;
  localparam int FD  = 8;
  localparam int TMO = 16;
  localparam logic [7:0] NEVER = 8'hFF;

  typedef struct packed {
    int               cyc;
    logic [15:0]      smp;
    logic [3:0][31:0] y;
    logic [3:0][7:0]  d;
  } strobe_t;

  typedef struct packed {
    int          cyc;
    logic [127:0] y;
    logic [3:0]  miss;
  } out_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          clear_err_i;
  logic          smp_valid_i;
  logic [15:0]   smp_i;
  logic          smp_ready_o;
  logic          fir_strobe_o;
  logic [15:0]   fir_sample_o;
  logic [3:0]    fir_done_i;
  logic [127:0]  fir_y_i;
  logic          out_valid_o;
  logic [127:0]  out_y_o;
  logic [3:0]    out_miss_o;
  logic          busy_o;
  logic          err_timeout_o;
  logic [15:0]   ovf_cnt_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] cfg_d [NL];
  logic [7:0] cfg_dup [NL];
  bit         fixed_y = 1'b0;
  bit         rand_d = 1'b0;
  int         tgt [NL];
  int         tgt2 [NL];
  logic [31:0] cur_y [NL];

  strobe_t strobe_q [$];
  out_t    out_q [$];

  student_fir_sched #(
    .NUM_LANES(NL), .DATA_SIZE(DW), .DATA_SIZE_OUT(DWO),
    .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_err_i(clear_err_i),
    .smp_valid_i(smp_valid_i), .smp_i(smp_i), .smp_ready_o(smp_ready_o),
    .fir_strobe_o(fir_strobe_o), .fir_sample_o(fir_sample_o),
    .fir_done_i(fir_done_i), .fir_y_i(fir_y_i),
    .out_valid_o(out_valid_o), .out_y_o(out_y_o), .out_miss_o(out_miss_o),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o), .ovf_cnt_o(ovf_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected result of one issued sample: a lane counts if its first done pulse
  // lands no later than the last watchdog cycle; otherwise it reads 0 and is missed.
  function automatic out_t model_out(input strobe_t s);
    out_t m;
    int   last;
    last   = 0;
    m.y    = '0;
    m.miss = 4'b0000;
    for (int k = 0; k < NL; k++) begin
      if (s.d[k] != NEVER && int'(s.d[k]) <= TMO) begin
        m.y[k*DWO +: DWO] = s.y[k];
        if (int'(s.d[k]) > last) last = int'(s.d[k]);
      end else begin
        m.miss[k] = 1'b1;
      end
    end
    if (m.miss != 4'b0000) m.cyc = s.cyc + TMO + 1;
    else                   m.cyc = s.cyc + ((last + 1 > 2) ? last + 1 : 2);
    return m;
  endfunction

  // Lane responder and monitor, working on the falling edge.
  initial begin : responder
    strobe_t s_rec;
    out_t    o_rec;
    int      r;
    fir_done_i = 4'b0000;
    fir_y_i    = '0;
    for (int k = 0; k < NL; k++) begin
      tgt[k] = -1; tgt2[k] = -1; cur_y[k] = 32'd0;
    end
    forever begin
      @(negedge clk);
      if (rst_i === 1'b1) begin
        for (int k = 0; k < NL; k++) begin
          tgt[k] = -1; tgt2[k] = -1;
        end
      end else begin
        if (fir_strobe_o === 1'b1) begin
          s_rec.cyc = cyc;
          s_rec.smp = fir_sample_o;
          for (int k = 0; k < NL; k++) begin
            if (rand_d) begin
              r = $urandom_range(0, 7);
              s_rec.d[k] = (r == 0) ? NEVER : 8'($urandom_range(0, TMO));
            end else begin
              s_rec.d[k] = cfg_d[k];
            end
            cur_y[k]   = fixed_y ? 32'(k + 1) : $urandom;
            s_rec.y[k] = cur_y[k];
            tgt[k]  = (s_rec.d[k] == NEVER) ? -1 : cyc + int'(s_rec.d[k]);
            tgt2[k] = (s_rec.d[k] == NEVER || cfg_dup[k] == NEVER || rand_d) ? -1 :
                      cyc + int'(s_rec.d[k]) + int'(cfg_dup[k]);
          end
          strobe_q.push_back(s_rec);
        end
        if (out_valid_o === 1'b1) begin
          o_rec.cyc  = cyc;
          o_rec.y    = out_y_o;
          o_rec.miss = out_miss_o;
          out_q.push_back(o_rec);
        end
      end
      for (int k = 0; k < NL; k++) begin
        fir_done_i[k] = (tgt[k] == cyc) || (tgt2[k] == cyc);
        fir_y_i[k*DWO +: DWO] = (tgt[k] == cyc) ? cur_y[k] : $urandom;
      end
    end
  end

  initial begin : global_guard
    #400000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "bench timeout");
  end

  task automatic push(input logic [15:0] v, output int pc);
    @(negedge clk);
    smp_valid_i = 1'b1;
    smp_i       = v;
    pc          = cyc;
    @(negedge clk);
    smp_valid_i = 1'b0;
  endtask

  task automatic wait_outs(input int n, input int budget);
    for (int i = 0; i < budget && out_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    cfg_d[0] = 8'(d0); cfg_d[1] = 8'(d1); cfg_d[2] = 8'(d2); cfg_d[3] = 8'(d3);
    for (int k = 0; k < NL; k++) cfg_dup[k] = NEVER;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; enable_i = 1'b0; clear_err_i = 1'b0; smp_valid_i = 1'b0; smp_i = 16'h0000;
    set_delays(5, 5, 5, 5);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (smp_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", smp_ready_o); end
    checks++;
    if ({fir_strobe_o, out_valid_o, busy_o, err_timeout_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {fir_strobe_o, out_valid_o, busy_o, err_timeout_o});
    end
    checks++;
    if ({fir_sample_o, out_y_o, out_miss_o, ovf_cnt_o} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {fir_sample_o, out_y_o, out_miss_o, ovf_cnt_o});
    end
  endtask

  task automatic test_single;
    int pc;
    logic [127:0] exp_y;
    exp_y = {32'd4, 32'd3, 32'd2, 32'd1};
    strobe_q.delete(); out_q.delete();
    enable_i = 1'b1; fixed_y = 1'b1;
    set_delays(5, 5, 5, 5);
    push(16'h0100, pc);
    repeat (14) @(negedge clk);
    fixed_y = 1'b0;
    checks++;
    if (strobe_q.size() != 1 || out_q.size() != 1) begin
      errors++; $display("FAIL single_count: strobes=%0d outs=%0d want 1/1", strobe_q.size(), out_q.size());
    end else begin
      checks++;
      if (strobe_q[0].cyc != pc + 2) begin errors++; $display("FAIL single_latency: strobe cycle %0d want %0d", strobe_q[0].cyc, pc + 2); end
      checks++;
      if (strobe_q[0].smp !== 16'h0100) begin errors++; $display("FAIL single_sample: got %h want 0100", strobe_q[0].smp); end
      checks++;
      if (out_q[0].y !== exp_y) begin errors++; $display("FAIL single_y: got %h want %h", out_q[0].y, exp_y); end
      checks++;
      if (out_q[0].miss !== 4'b0000) begin errors++; $display("FAIL single_miss: got %b want 0000", out_q[0].miss); end
      checks++;
      if (out_q[0].cyc != strobe_q[0].cyc + 6) begin errors++; $display("FAIL single_out_cycle: got %0d want %0d", out_q[0].cyc, strobe_q[0].cyc + 6); end
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: busy %b want 0", busy_o); end
  endtask

  task automatic test_staggered;
    int pc;
    out_t m;
    strobe_q.delete(); out_q.delete();
    set_delays(3, 7, 1, 9);
    cfg_dup[0] = 8'd2; cfg_dup[2] = 8'd3;
    push(16'($urandom), pc);
    repeat (18) @(negedge clk);
    checks++;
    if (strobe_q.size() != 1 || out_q.size() != 1) begin
      errors++; $display("FAIL stagger_count: strobes=%0d outs=%0d want 1/1", strobe_q.size(), out_q.size());
    end else begin
      m = model_out(strobe_q[0]);
      checks++;
      if (out_q[0].cyc != strobe_q[0].cyc + 10) begin errors++; $display("FAIL stagger_cycle: got %0d want %0d", out_q[0].cyc, strobe_q[0].cyc + 10); end
      checks++;
      if (out_q[0].y !== m.y) begin errors++; $display("FAIL stagger_y: got %h want %h", out_q[0].y, m.y); end
      checks++;
      if (out_q[0].miss !== 4'b0000) begin errors++; $display("FAIL stagger_miss: got %b want 0000", out_q[0].miss); end
    end
  endtask

  task automatic test_timeout;
    int pc;
    out_t m;
    strobe_q.delete(); out_q.delete();
    set_delays(2, 4, 255, 6);
    checks++;
    if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_pre_err: got %b want 0", err_timeout_o); end
    push(16'h0BAD, pc);
    wait_outs(1, 40);
    checks++;
    if (strobe_q.size() != 1 || out_q.size() != 1) begin
      errors++; $display("FAIL tmo_count: strobes=%0d outs=%0d want 1/1", strobe_q.size(), out_q.size());
    end else begin
      m = model_out(strobe_q[0]);
      checks++;
      if (out_q[0].cyc != strobe_q[0].cyc + 17) begin errors++; $display("FAIL tmo_cycle: got %0d want %0d", out_q[0].cyc, strobe_q[0].cyc + 17); end
      checks++;
      if (out_q[0].y !== m.y || out_q[0].y[64 +: 32] !== 32'd0) begin errors++; $display("FAIL tmo_y: got %h want %h", out_q[0].y, m.y); end
      checks++;
      if (out_q[0].miss !== 4'b0100) begin errors++; $display("FAIL tmo_miss: got %b want 0100", out_q[0].miss); end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (err_timeout_o !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b want 1", err_timeout_o); end
    checks++;
    if (out_miss_o !== 4'b0100) begin errors++; $display("FAIL tmo_miss_hold: got %b want 0100", out_miss_o); end
    clear_err_i = 1'b1;
    @(negedge clk);
    clear_err_i = 1'b0;
    checks++;
    if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b want 0", err_timeout_o); end
  endtask

  task automatic test_overflow;
    logic [15:0] v [10];
    out_t m;
    strobe_q.delete(); out_q.delete();
    enable_i = 1'b0; rand_d = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v[i] = 16'($urandom);
      @(negedge clk);
      checks++;
      if (smp_ready_o !== (i < FD)) begin errors++; $display("FAIL ovf_ready_%0d: got %b want %b", i, smp_ready_o, (i < FD)); end
      smp_valid_i = 1'b1;
      smp_i       = v[i];
    end
    @(negedge clk);
    smp_valid_i = 1'b0;
    checks++;
    if (ovf_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_count: got %0d want 2", ovf_cnt_o); end
    checks++;
    if (busy_o !== 1'b0 || strobe_q.size() != 0) begin errors++; $display("FAIL ovf_no_issue: busy %b strobes %0d want 0/0", busy_o, strobe_q.size()); end
    enable_i = 1'b1;
    wait_outs(FD, FD * 24);
    checks++;
    if (out_q.size() != FD || strobe_q.size() != FD) begin
      errors++; $display("FAIL ovf_drain: outs=%0d strobes=%0d want %0d", out_q.size(), strobe_q.size(), FD);
    end else begin
      for (int i = 0; i < FD; i++) begin
        m = model_out(strobe_q[i]);
        checks++;
        if (strobe_q[i].smp !== v[i]) begin errors++; $display("FAIL ovf_order_%0d: got %h want %h", i, strobe_q[i].smp, v[i]); end
        checks++;
        if (out_q[i].cyc != m.cyc || out_q[i].y !== m.y || out_q[i].miss !== m.miss) begin
          errors++; $display("FAIL ovf_result_%0d: got c%0d %h %b want c%0d %h %b", i, out_q[i].cyc, out_q[i].y, out_q[i].miss, m.cyc, m.y, m.miss);
        end
        if (i > 0) begin
          checks++;
          if (strobe_q[i].cyc - strobe_q[i-1].cyc < 4) begin errors++; $display("FAIL ovf_gap_%0d: got %0d want >=4", i, strobe_q[i].cyc - strobe_q[i-1].cyc); end
        end
      end
    end
    rand_d = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (smp_ready_o !== 1'b1) begin errors++; $display("FAIL ovf_ready_back: got %b want 1", smp_ready_o); end
    clear_err_i = 1'b1;
    @(negedge clk);
    clear_err_i = 1'b0;
    checks++;
    if (ovf_cnt_o !== 16'd0 || err_timeout_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0d/%b want 0/0", ovf_cnt_o, err_timeout_o); end
  endtask

  task automatic test_back_to_back;
    int pc;
    logic [15:0] v [6];
    out_t m;
    strobe_q.delete(); out_q.delete();
    set_delays(4, 4, 4, 4);
    for (int i = 0; i < 6; i++) begin
      v[i] = 16'($urandom);
      push(v[i], pc);
    end
    wait_outs(6, 100);
    checks++;
    if (out_q.size() != 6 || strobe_q.size() != 6) begin
      errors++; $display("FAIL b2b_count: outs=%0d strobes=%0d want 6", out_q.size(), strobe_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        m = model_out(strobe_q[i]);
        checks++;
        if (strobe_q[i].smp !== v[i]) begin errors++; $display("FAIL b2b_order_%0d: got %h want %h", i, strobe_q[i].smp, v[i]); end
        checks++;
        if (out_q[i].y !== m.y || out_q[i].miss !== 4'b0000) begin errors++; $display("FAIL b2b_result_%0d: got %h %b want %h 0000", i, out_q[i].y, out_q[i].miss, m.y); end
        if (i > 0) begin
          checks++;
          if (strobe_q[i].cyc - strobe_q[i-1].cyc != 7) begin errors++; $display("FAIL b2b_period_%0d: got %0d want 7", i, strobe_q[i].cyc - strobe_q[i-1].cyc); end
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int pc;
    out_t m;
    strobe_q.delete(); out_q.delete();
    set_delays(255, 255, 255, 255);
    push(16'h1234, pc);
    repeat (4) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b want 1", busy_o); end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({busy_o, out_valid_o, smp_ready_o} !== 3'b001) begin errors++; $display("FAIL rmid_async: got %b want 001", {busy_o, out_valid_o, smp_ready_o}); end
    @(negedge clk);
    rst_i = 1'b0;
    set_delays(1, 2, 3, 4);
    push(16'h0200, pc);
    repeat (14) @(negedge clk);
    checks++;
    if (out_q.size() != 1 || strobe_q.size() != 2) begin
      errors++; $display("FAIL rmid_count: outs=%0d strobes=%0d want 1/2", out_q.size(), strobe_q.size());
    end else begin
      m = model_out(strobe_q[1]);
      checks++;
      if (strobe_q[1].smp !== 16'h0200) begin errors++; $display("FAIL rmid_sample: got %h want 0200", strobe_q[1].smp); end
      checks++;
      if (out_q[0].cyc != m.cyc || out_q[0].y !== m.y) begin errors++; $display("FAIL rmid_result: got c%0d %h want c%0d %h", out_q[0].cyc, out_q[0].y, m.cyc, m.y); end
    end
    checks++;
    if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", err_timeout_o); end
  endtask

  task automatic test_random;
    int pc;
    logic [15:0] v [8];
    out_t m;
    logic exp_err;
    strobe_q.delete(); out_q.delete();
    rand_d = 1'b1;
    exp_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      v[i] = 16'($urandom);
      push(v[i], pc);
    end
    wait_outs(8, 8 * 24);
    rand_d = 1'b0;
    checks++;
    if (out_q.size() != 8 || strobe_q.size() != 8) begin
      errors++; $display("FAIL rnd_count: outs=%0d strobes=%0d want 8", out_q.size(), strobe_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        m = model_out(strobe_q[i]);
        if (m.miss != 4'b0000) exp_err = 1'b1;
        checks++;
        if (strobe_q[i].smp !== v[i]) begin errors++; $display("FAIL rnd_order_%0d: got %h want %h", i, strobe_q[i].smp, v[i]); end
        checks++;
        if (out_q[i].cyc != m.cyc || out_q[i].y !== m.y || out_q[i].miss !== m.miss) begin
          errors++; $display("FAIL rnd_result_%0d: got c%0d %h %b want c%0d %h %b", i, out_q[i].cyc, out_q[i].y, out_q[i].miss, m.cyc, m.y, m.miss);
        end
        if (i > 0) begin
          checks++;
          if (strobe_q[i].cyc < out_q[i-1].cyc + 2) begin errors++; $display("FAIL rnd_gap_%0d: strobe c%0d want >= c%0d", i, strobe_q[i].cyc, out_q[i-1].cyc + 2); end
        end
      end
      @(negedge clk);
      checks++;
      if (err_timeout_o !== exp_err) begin errors++; $display("FAIL rnd_err: got %b want %b", err_timeout_o, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_staggered();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
